// File: rtl/alu_arb_pkg.sv
// Shared encodings for the ALU arbiter and the ALU control sequencer.
package alu_arb_pkg;

  localparam int OP_W = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } arb_state_e;

  localparam logic [OP_W-1:0] OP_ADD = 3'd0;
  localparam logic [OP_W-1:0] OP_SUB = 3'd1;
  localparam logic [OP_W-1:0] OP_AND = 3'd2;
  localparam logic [OP_W-1:0] OP_OR  = 3'd3;
  localparam logic [OP_W-1:0] OP_XOR = 3'd4;
  localparam logic [OP_W-1:0] OP_PA  = 3'd5;
  localparam logic [OP_W-1:0] OP_SHL = 3'd6;
  localparam logic [OP_W-1:0] OP_SHR = 3'd7;

endpackage

// File: rtl/alu_arbiter_rr_picker.sv
// Combinational round-robin pick: first requester strictly after i_last, wrapping.
module rr_picker #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IDX_W-1:0]   i_last,
  output logic               o_found,
  output logic [NUM_REQ-1:0] o_gnt,
  output logic [IDX_W-1:0]   o_idx
);

  localparam int POS_W = $clog2(2*NUM_REQ);

  logic [NUM_REQ-1:0]   w_mask;
  logic [2*NUM_REQ-1:0] w_dbl;
  logic [POS_W-1:0]     w_pos;

  // Low half holds only requesters above last; high half is the wrapped copy,
  // so the lowest set bit of the doubled vector is the round-robin winner.
  always_comb begin
    w_mask = '0;
    for (int i = 0; i < NUM_REQ; i++) w_mask[i] = (i > int'(i_last));
    w_dbl = {i_req, i_req & w_mask};
    w_pos = '0;
    for (int p = 2*NUM_REQ-1; p >= 0; p--)
      if (w_dbl[p]) w_pos = POS_W'(p);
  end

  assign o_found = |i_req;
  assign o_idx   = (int'(w_pos) >= NUM_REQ) ? IDX_W'(int'(w_pos) - NUM_REQ) : IDX_W'(w_pos);
  assign o_gnt   = o_found ? (NUM_REQ'(1) << o_idx) : '0;

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU sequencer between NUM_REQ requesters,
// with a watchdog that aborts transactions whose result never arrives.
module alu_arbiter
  import alu_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [OP_W*NUM_REQ-1:0]   req_op,
  input  logic [DATA_W*NUM_REQ-1:0] req_a,
  input  logic [DATA_W*NUM_REQ-1:0] req_b,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_data,
  output logic                      rsp_zero,
  output logic                      rsp_carry,
  output logic                      rsp_err,
  output logic                      alu_start,
  output logic [OP_W-1:0]           alu_op_sel,
  output logic [DATA_W-1:0]         alu_a,
  output logic [DATA_W-1:0]         alu_b,
  input  logic                      alu_busy,
  input  logic [DATA_W-1:0]         alu_result,
  input  logic                      alu_zero,
  input  logic                      alu_carry,
  input  logic                      alu_result_valid
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(TIMEOUT);

  arb_state_e          r_state;
  logic [IDX_W-1:0]    r_last;
  logic [IDX_W-1:0]    r_idx;
  logic [CNT_W-1:0]    r_cnt;
  logic [NUM_REQ-1:0]  r_gnt;
  logic [NUM_REQ-1:0]  r_rsp_valid;
  logic [DATA_W-1:0]   r_rsp_data;
  logic                r_rsp_zero;
  logic                r_rsp_carry;
  logic                r_rsp_err;
  logic [OP_W-1:0]     r_op;
  logic [DATA_W-1:0]   r_a;
  logic [DATA_W-1:0]   r_b;

  logic                w_found;
  logic [NUM_REQ-1:0]  w_pick_gnt;
  logic [IDX_W-1:0]    w_pick_idx;
  logic                w_start;
  logic                w_expired;

  rr_picker #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_pick (
    .i_req   (req),
    .i_last  (r_last),
    .o_found (w_found),
    .o_gnt   (w_pick_gnt),
    .o_idx   (w_pick_idx)
  );

  assign w_start   = (r_state == ST_ISSUE) && !alu_busy;
  assign w_expired = (r_cnt == CNT_W'(TIMEOUT-1));

  // Counter saturates at expiry: a start issued on the last allowed cycle
  // still moves to WAIT, which then aborts on its first cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_last      <= IDX_W'(NUM_REQ-1);
      r_idx       <= '0;
      r_cnt       <= '0;
      r_gnt       <= '0;
      r_rsp_valid <= '0;
      r_rsp_data  <= '0;
      r_rsp_zero  <= 1'b0;
      r_rsp_carry <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_op        <= '0;
      r_a         <= '0;
      r_b         <= '0;
    end else begin
      r_rsp_valid <= '0;
      case (r_state)
        ST_IDLE: begin
          r_cnt <= '0;
          if (w_found) begin
            r_idx   <= w_pick_idx;
            r_gnt   <= w_pick_gnt;
            r_op    <= req_op[OP_W*w_pick_idx +: OP_W];
            r_a     <= req_a[DATA_W*w_pick_idx +: DATA_W];
            r_b     <= req_b[DATA_W*w_pick_idx +: DATA_W];
            r_state <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (!w_expired) r_cnt <= r_cnt + 1'b1;
          if (w_start) begin
            r_state <= ST_WAIT;
          end else if (w_expired) begin
            r_rsp_data  <= '0;
            r_rsp_zero  <= 1'b0;
            r_rsp_carry <= 1'b0;
            r_rsp_err   <= 1'b1;
            r_rsp_valid <= r_gnt;
            r_state     <= ST_RESP;
          end
        end
        ST_WAIT: begin
          if (!w_expired) r_cnt <= r_cnt + 1'b1;
          if (alu_result_valid) begin
            r_rsp_data  <= alu_result;
            r_rsp_zero  <= alu_zero;
            r_rsp_carry <= alu_carry;
            r_rsp_err   <= 1'b0;
            r_rsp_valid <= r_gnt;
            r_state     <= ST_RESP;
          end else if (w_expired) begin
            r_rsp_data  <= '0;
            r_rsp_zero  <= 1'b0;
            r_rsp_carry <= 1'b0;
            r_rsp_err   <= 1'b1;
            r_rsp_valid <= r_gnt;
            r_state     <= ST_RESP;
          end
        end
        ST_RESP: begin
          r_last  <= r_idx;
          r_gnt   <= '0;
          r_cnt   <= '0;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign gnt        = r_gnt;
  assign rsp_valid  = r_rsp_valid;
  assign rsp_data   = r_rsp_data;
  assign rsp_zero   = r_rsp_zero;
  assign rsp_carry  = r_rsp_carry;
  assign rsp_err    = r_rsp_err;
  assign alu_start  = w_start;
  assign alu_op_sel = r_op;
  assign alu_a      = r_a;
  assign alu_b      = r_b;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: stimulus pushes expected responses, a monitor pops and checks.
module tb_alu_arbiter;
  import alu_arb_pkg::*;

  localparam int NR = 4;
  localparam int DW = 8;
  localparam int TO = 16;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NR-1:0]     req = '0;
  logic [3*NR-1:0]   req_op = '0;
  logic [DW*NR-1:0]  req_a = '0;
  logic [DW*NR-1:0]  req_b = '0;
  logic [NR-1:0]     gnt, rsp_valid;
  logic [DW-1:0]     rsp_data;
  logic              rsp_zero, rsp_carry, rsp_err, alu_start;
  logic [2:0]        alu_op_sel;
  logic [DW-1:0]     alu_a, alu_b;
  logic              alu_busy;
  logic [DW-1:0]     alu_result = '0;
  logic              alu_zero = 1'b0;
  logic              alu_carry = 1'b0;
  logic              alu_result_valid = 1'b0;

  logic              force_busy = 1'b0;
  logic              no_valid = 1'b0;
  int                seq_cnt = 0;
  int                cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  alu_arbiter #(.NUM_REQ(NR), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_op(req_op), .req_a(req_a), .req_b(req_b),
    .gnt(gnt), .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_zero(rsp_zero),
    .rsp_carry(rsp_carry), .rsp_err(rsp_err), .alu_start(alu_start), .alu_op_sel(alu_op_sel),
    .alu_a(alu_a), .alu_b(alu_b), .alu_busy(alu_busy), .alu_result(alu_result),
    .alu_zero(alu_zero), .alu_carry(alu_carry), .alu_result_valid(alu_result_valid)
  );

  // Sequencer stand-in: start seen at edge N, result_valid high in the cycle after edge N+2.
  function automatic logic [DW:0] seq_alu(input logic [2:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b);
    case (op)
      OP_ADD:  return {1'b0, a} + {1'b0, b};
      OP_SUB:  return {1'b0, a} - {1'b0, b};
      OP_AND:  return {1'b0, a & b};
      OP_OR:   return {1'b0, a | b};
      OP_XOR:  return {1'b0, a ^ b};
      default: return {1'b0, a};
    endcase
  endfunction

  assign alu_busy = force_busy;

  always @(posedge clk) begin
    alu_result_valid <= 1'b0;
    if (!rst_n) begin
      seq_cnt <= 0;
    end else if (alu_start) begin
      seq_cnt <= 2;
      {alu_carry, alu_result} <= seq_alu(alu_op_sel, alu_a, alu_b);
      alu_zero <= (seq_alu(alu_op_sel, alu_a, alu_b) & 9'h0FF) == 9'h000;
    end else if (seq_cnt != 0) begin
      seq_cnt <= seq_cnt - 1;
      if (seq_cnt == 1 && !no_valid) alu_result_valid <= 1'b1;
    end
  end

  typedef struct {
    int           idx;
    logic [7:0]   data;
    logic         z;
    logic         c;
    logic         err;
    int           at;
  } exp_t;

  exp_t sb[$];
  exp_t m_e;
  int   n_chk = 0;
  int   n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic push(input int idx, input logic [7:0] d, input logic z, input logic c,
                      input logic err, input int at);
    exp_t e;
    e.idx = idx; e.data = d; e.z = z; e.c = c; e.err = err; e.at = at;
    sb.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic goto(input int c);
    while (cyc < c) tick();
  endtask

  task automatic set_req(input int i, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    req[i] = 1'b1;
    req_op[3*i +: 3] = op;
    req_a[DW*i +: DW] = a;
    req_b[DW*i +: DW] = b;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 100) begin tick(); n++; end
    if (sb.size() != 0) begin
      chk("drain_timeout", sb.size(), 0);
      sb.delete();
    end
    tick();
  endtask

  // Monitor: one-hot invariants every cycle, scoreboard pop on any response.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        chk("gnt_onehot0", {31'd0, $onehot0(gnt)}, 1);
        chk("rsp_onehot0", {31'd0, $onehot0(rsp_valid)}, 1);
        if (rsp_valid != '0) begin
          if (sb.size() == 0) begin
            chk("unexpected_rsp", rsp_valid, 0);
          end else begin
            m_e = sb.pop_front();
            chk("rsp_owner", rsp_valid, 32'd1 << m_e.idx);
            chk("rsp_cycle", cyc, m_e.at);
            chk("rsp_data", rsp_data, m_e.data);
            chk("rsp_zero", rsp_zero, m_e.z);
            chk("rsp_carry", rsp_carry, m_e.c);
            chk("rsp_err", rsp_err, m_e.err);
          end
        end
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    tick(); tick(); tick();
    chk("rst_gnt", gnt, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_err", rsp_err, 0);
    chk("rst_alu_start", alu_start, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_flags", {rsp_zero, rsp_carry}, 0);
    chk("rst_alu_ops", {alu_op_sel, alu_a, alu_b}, 0);
    rst_n = 1'b1;

    // Single request from requester 2
    tick(); c0 = cyc;
    set_req(2, OP_ADD, 8'h05, 8'h03);
    push(2, 8'h08, 1'b0, 1'b0, 1'b0, c0 + 5);
    tick();
    chk("single_gnt", gnt, 4'b0100);
    chk("single_start", alu_start, 1);
    chk("single_a", alu_a, 8'h05);
    chk("single_b", alu_b, 8'h03);
    chk("single_op", alu_op_sel, OP_ADD);
    req[2] = 1'b0;
    tick();
    chk("single_start_once", alu_start, 0);
    chk("single_gnt_held", gnt, 4'b0100);
    drain();

    // All four from reset: order 0,1,2,3
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    c0 = cyc;
    set_req(0, OP_ADD, 8'hF0, 8'h20);
    set_req(1, OP_SUB, 8'h33, 8'h33);
    set_req(2, OP_AND, 8'hF0, 8'h0F);
    set_req(3, OP_XOR, 8'hA5, 8'h0F);
    push(0, 8'h10, 1'b0, 1'b1, 1'b0, c0 + 5);
    push(1, 8'h00, 1'b1, 1'b0, 1'b0, c0 + 11);
    push(2, 8'h00, 1'b1, 1'b0, 1'b0, c0 + 17);
    push(3, 8'hAA, 1'b0, 1'b0, 1'b0, c0 + 23);
    for (int k = 0; k < 4; k++) begin
      goto(c0 + 1 + 6*k);
      chk("all4_gnt", gnt, 32'd1 << k);
      req[k] = 1'b0;
    end
    drain();

    // Fairness: 0 and 3 held, grants alternate
    tick(); c0 = cyc;
    set_req(0, OP_OR, 8'h12, 8'h40);
    set_req(3, OP_SUB, 8'h01, 8'h02);
    push(0, 8'h52, 1'b0, 1'b0, 1'b0, c0 + 5);
    push(3, 8'hFF, 1'b0, 1'b1, 1'b0, c0 + 11);
    push(0, 8'h52, 1'b0, 1'b0, 1'b0, c0 + 17);
    push(3, 8'hFF, 1'b0, 1'b1, 1'b0, c0 + 23);
    for (int k = 0; k < 4; k++) begin
      goto(c0 + 1 + 6*k);
      chk("fair_gnt", gnt, (k % 2 == 1) ? 32'd8 : 32'd1);
    end
    req[0] = 1'b0; req[3] = 1'b0;
    drain();

    // Busy stall for cycles 1-3
    tick(); c0 = cyc;
    force_busy = 1'b1;
    set_req(1, OP_ADD, 8'h7F, 8'h01);
    push(1, 8'h80, 1'b0, 1'b0, 1'b0, c0 + 8);
    tick();
    chk("busy_gnt", gnt, 4'b0010);
    chk("busy_start_c1", alu_start, 0);
    req[1] = 1'b0;
    tick(); chk("busy_start_c2", alu_start, 0);
    tick(); chk("busy_start_c3", alu_start, 0);
    tick(); force_busy = 1'b0; #1;
    chk("busy_start_c4", alu_start, 1);
    tick(); chk("busy_start_c5", alu_start, 0);
    drain();

    // Timeout then a clean transaction
    tick(); c0 = cyc;
    no_valid = 1'b1;
    set_req(2, OP_AND, 8'hFF, 8'hFF);
    push(2, 8'h00, 1'b0, 1'b0, 1'b1, c0 + 17);
    tick(); req[2] = 1'b0;
    drain();
    no_valid = 1'b0;
    tick(); c0 = cyc;
    set_req(0, OP_ADD, 8'hFF, 8'h01);
    push(0, 8'h00, 1'b1, 1'b1, 1'b0, c0 + 5);
    tick(); req[0] = 1'b0;
    drain();

    // Reset while requester 1 is in WAIT
    tick(); c0 = cyc;
    set_req(1, OP_XOR, 8'hA5, 8'h0F);
    tick(); chk("rstw_gnt", gnt, 4'b0010);
    tick(); rst_n = 1'b0;
    tick(); rst_n = 1'b1;
    chk("rstw_gnt_clear", gnt, 0);
    chk("rstw_no_rsp", rsp_valid, 0);
    chk("rstw_alu_a", alu_a, 0);
    set_req(3, OP_ADD, 8'h10, 8'h20);
    push(1, 8'hAA, 1'b0, 1'b0, 1'b0, c0 + 8);
    push(3, 8'h30, 1'b0, 1'b0, 1'b0, c0 + 14);
    tick(); chk("rstw_first_gnt", gnt, 4'b0010);
    req[1] = 1'b0;
    goto(c0 + 10); chk("rstw_second_gnt", gnt, 4'b1000);
    req[3] = 1'b0;
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
Round-robin arbiter sharing the single ALU datapath and its control sequencer between NUM_REQ requesters. It accepts one operation at a time: it latches the requester's opcode and operands, pulses the sequencer start, waits for result_valid, and returns result and flags to the granted requester. A watchdog aborts transactions whose result never arrives.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
DATA_W, 8, operand/result width
TIMEOUT, 16, max cycles in ISSUE+WAIT before abort (>=8)

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
req  in  NUM_REQ  per-requester request level
req_op  in  3*NUM_REQ  packed opcodes, requester i at [3i+2:3i]
req_a  in  DATA_W*NUM_REQ  packed operand A
req_b  in  DATA_W*NUM_REQ  packed operand B
gnt  out  NUM_REQ  one-hot grant, held for the whole transaction
rsp_valid  out  NUM_REQ  one-cycle response pulse to the owning requester
rsp_data  out  DATA_W  registered result, shared by all requesters
rsp_zero  out  1  registered zero flag
rsp_carry  out  1  registered carry flag
rsp_err  out  1  timeout indication, qualified by rsp_valid
alu_start  out  1  start pulse to the sequencer
alu_op_sel  out  3  latched opcode to the sequencer
alu_a  out  DATA_W  latched operand A
alu_b  out  DATA_W  latched operand B
alu_busy  in  1  sequencer busy
alu_result  in  DATA_W  ALU result
alu_zero  in  1  ALU zero flag
alu_carry  in  1  ALU carry flag
alu_result_valid  in  1  sequencer result-valid (DONE state)

Behaviour:
- Reset (rst_n low at posedge): state IDLE; gnt, rsp_valid, rsp_err, alu_start = 0; rsp_data, rsp_zero, rsp_carry, alu_op_sel, alu_a, alu_b, timeout counter = 0. The last-grant pointer is NUM_REQ-1, so requester 0 has first priority.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE: if any req is high, the round-robin pick starts at last+1 and wraps. At the edge, latch the index, opcode and operands; set gnt one-hot; go to ISSUE. If no req is high, stay in IDLE.
- ISSUE: alu_start = !alu_busy (combinational). When the start is issued, go to WAIT. Otherwise stay in ISSUE.
- WAIT: on alu_result_valid, capture alu_result/zero/carry into rsp_*, clear rsp_err, and go to RESP.
- Timeout: the counter runs in ISSUE and WAIT and clears in IDLE. If it reaches TIMEOUT-1 without valid, go to RESP with rsp_err=1 and rsp_data, rsp_zero, rsp_carry = 0. If valid arrives in the same cycle as expiry, valid wins.
- RESP: rsp_valid[idx]=1 for exactly one cycle; last <= idx; gnt clears at the exit edge; go to IDLE.
- alu_op_sel, alu_a, alu_b are registers. They stay stable from ISSUE through RESP and hold their value when idle.
- Latency with the sequencer idle: req sampled in cycle 0; alu_start in cycle 1; result_valid in cycle 4; rsp_valid in cycle 5; back in IDLE in cycle 6. Back-to-back grants are therefore 6 cycles apart.
- Requester rules:
  - req is sampled only in IDLE.
  - Deasserting req before grant withdraws the request.
  - Deasserting req after grant does not cancel; the response still pulses.
  - Operands are captured once, so later changes are ignored.
- Reset mid-transaction: at the next edge, return to IDLE with all outputs at reset values. No rsp_valid is emitted. The sequencer shares rst_n.
- At most one bit of gnt and of rsp_valid is ever high.

Decomposition:
- Package alu_arb_pkg:
  - state encodings (IDLE=2'd0, ISSUE=2'd1, WAIT=2'd2, RESP=2'd3)
  - OP_W=3
  - opcode constants shared with the sequencer
- Sub-module rr_picker: combinational. Inputs are the req vector and the last index; outputs are a found flag and the one-hot/binary winner, using a double-width mask-and-priority scheme. Timeout counter and FSM live in alu_arbiter.

Test Plan:
- Single request: req[2]=1, op=3'b000, a=8'h05, b=8'h03; bench ALU returns 8'h08, zero=0. Required: gnt=4'b0100 from cycle 1; alu_start in cycle 1 only with alu_a=05, alu_b=03; rsp_valid=4'b0100 in cycle 5; rsp_data=08; rsp_err=0.
- All four requesting from reset: grant order 0,1,2,3. rsp_valid pulses in cycles 5, 11, 17, 23; each rsp_data matches that requester's operands.
- Fairness: req[0] and req[3] held high continuously. Grants alternate 0,3,0,3; neither requester is granted twice in a row.
- Busy stall: alu_busy held high cycles 1-3 after grant. alu_start is first asserted in cycle 4; rsp_valid is still exactly one pulse.
- Timeout: bench never asserts alu_result_valid, TIMEOUT=16. rsp_valid pulses with rsp_err=1 and rsp_data=00 16 cycles after ISSUE entry. The next request then completes with rsp_err=0.
- Reset in WAIT: rst_n low for one cycle while req[1] is granted. Next cycle gnt=0 and no rsp_valid. After release, with req[1] and req[3] pending, req[1] is granted first.
